// File: rtl/bin2bcd_iter_pkg.sv
// Shared definitions for the iterative binary-to-BCD converter.
// FSM state encodings and the counter-width helper.
package bin2bcd_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit of the shift-and-add-3 step: add 3 when the digit exceeds 4.
// Result stays 4 bits; the carry cannot occur for legal digits.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit > 4'd4) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_iter.sv
// Sequential binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional leading-zero blanking output enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_iter
    import bin2bcd_iter_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BIN_W-1:0]    bin,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                ovf
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]   blank
`endif
);

    localparam int CW = clog2(BIN_W + 1);

    state_t              state;
    logic [BIN_W-1:0]    shreg;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] bcd_shift;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (bcd[4*k +: 4]),
            .adjusted (adj[4*k +: 4])
        );
    end

    // Adjusted digits shift up one place; the next binary MSB enters digit 0.
    assign bcd_shift = {adj[4*DIGITS-2:0], shreg[BIN_W-1]};

`ifdef BIN2BCD_BLANK_EN
    function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] b;
        logic              z;
        b = '0;
        z = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            z    = z & (v[4*k +: 4] == 4'd0);
            b[k] = z;
        end
        return b;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            bcd       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef BIN2BCD_BLANK_EN
            blank     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        shreg    <= bin;
                        bcd      <= '0;
                        ovf      <= 1'b0;
                        cnt      <= CW'(BIN_W);
                        in_ready <= 1'b0;
                        state    <= ST_SHIFT;
`ifdef BIN2BCD_BLANK_EN
                        blank    <= blank_of('0);
`endif
                    end
                end
                ST_SHIFT: begin
                    bcd   <= bcd_shift;
                    shreg <= shreg << 1;
                    ovf   <= ovf | adj[4*DIGITS-1];
                    cnt   <= cnt - CW'(1);
`ifdef BIN2BCD_BLANK_EN
                    blank <= blank_of(bcd_shift);
`endif
                    if (cnt == CW'(1)) begin
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
